// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/latch/execute controller for the 16-bit datapath.
// Drives memory, register file and a combinational ALU; owns PC and PSR.
module alu_sequencer #(
  parameter int                WIDTH    = 16,
  parameter logic [WIDTH-1:0]  RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic [3:0]       rf_ra_src,
  output logic [3:0]       rf_ra_dst,
  input  logic [WIDTH-1:0] rf_rd_src,
  input  logic [WIDTH-1:0] rf_rd_dst,
  output logic [3:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic             rf_we,
  output logic [WIDTH-1:0] alu_rsrc,
  output logic [WIDTH-1:0] alu_rdest,
  output logic [3:0]       alucont,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [4:0]       alu_psr,
  output logic [4:0]       psr,
  output logic [WIDTH-1:0] pc,
  output logic             illegal_op
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LATCH = 2'd1,
    S_EXEC  = 2'd2,
    S_LDWB  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       ALU_ADD = 4'b0000;
  localparam logic [3:0]       ALU_SUB = 4'b0001;
  localparam logic [3:0]       ALU_CMP = 4'b0101;

  // Shared arithmetic/logic code (R-type ext or I-type op) -> {valid, alucont}
  function automatic logic [4:0] arith_code(input logic [3:0] code);
    case (code)
      4'b0101: arith_code = {1'b1, 4'b0000};
      4'b1001: arith_code = {1'b1, 4'b0001};
      4'b0001: arith_code = {1'b1, 4'b0010};
      4'b0011: arith_code = {1'b1, 4'b0011};
      4'b0010: arith_code = {1'b1, 4'b0100};
      4'b1011: arith_code = {1'b1, 4'b0101};
      4'b1101: arith_code = {1'b1, 4'b0110};
      default: arith_code = {1'b0, 4'b0000};
    endcase
  endfunction

  // Condition evaluation against flags {N,Z,L,F,C}
  function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] f);
    case (cond)
      4'b0000: cond_true = f[3];
      4'b0001: cond_true = ~f[3];
      4'b0010: cond_true = f[0];
      4'b0011: cond_true = ~f[0];
      4'b0100: cond_true = f[2];
      4'b0101: cond_true = ~f[2];
      4'b0110: cond_true = f[4];
      4'b0111: cond_true = ~f[4];
      4'b1000: cond_true = f[1];
      4'b1001: cond_true = ~f[1];
      4'b1010: cond_true = ~f[2] & ~f[3];
      4'b1011: cond_true = f[2] | f[3];
      4'b1100: cond_true = ~f[4] & ~f[3];
      4'b1101: cond_true = f[4] | f[3];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] pc_r, ipc_r, ir_r, ld_addr_r;
  logic [4:0]       psr_r, psr_next_s;

  logic [3:0]       op_s, rdst_s, ext_s;
  logic [4:0]       r_code_s, i_code_s;
  logic [WIDTH-1:0] imm_sext_s, imm_zext_s, lsh_imm_s;

  logic             dec_alu_s, dec_load_s, dec_store_s, dec_jump_s, dec_illegal_s;
  logic [3:0]       dec_cont_s;
  logic [WIDTH-1:0] dec_rsrc_s, dec_rdest_s, dec_target_s;

  assign op_s       = ir_r[15:12];
  assign rdst_s     = ir_r[11:8];
  assign ext_s      = ir_r[7:4];
  assign r_code_s   = arith_code(ext_s);
  assign i_code_s   = arith_code(op_s);
  assign imm_sext_s = {{(WIDTH-8){ir_r[7]}}, ir_r[7:0]};
  assign imm_zext_s = {{(WIDTH-8){1'b0}}, ir_r[7:0]};
  assign lsh_imm_s  = {{(WIDTH-5){1'b0}}, ir_r[4:0]};

  assign rf_ra_src  = ir_r[3:0];
  assign rf_ra_dst  = rdst_s;
  assign rf_wa      = rdst_s;
  assign pc         = pc_r;
  assign psr        = psr_r;

  // Instruction decode of the latched word; only consumed in EXEC
  always_comb begin
    dec_alu_s     = 1'b0;
    dec_cont_s    = 4'b0000;
    dec_rsrc_s    = ZERO;
    dec_rdest_s   = ZERO;
    dec_load_s    = 1'b0;
    dec_store_s   = 1'b0;
    dec_jump_s    = 1'b0;
    dec_target_s  = ZERO;
    dec_illegal_s = 1'b0;
    case (op_s)
      4'b0000: begin
        if (r_code_s[4]) begin
          dec_alu_s   = 1'b1;
          dec_cont_s  = r_code_s[3:0];
          dec_rsrc_s  = rf_rd_src;
          dec_rdest_s = rf_rd_dst;
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
      4'b1000: begin
        dec_rdest_s = rf_rd_dst;
        if (ext_s == 4'b0100) begin
          dec_alu_s  = 1'b1;
          dec_cont_s = 4'b0111;
          dec_rsrc_s = rf_rd_src;
        end else if (ext_s[3:1] == 3'b000) begin
          dec_alu_s  = 1'b1;
          dec_cont_s = 4'b1000;
          dec_rsrc_s = lsh_imm_s;
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
      4'b1111: begin
        dec_alu_s   = 1'b1;
        dec_cont_s  = 4'b1001;
        dec_rdest_s = imm_zext_s;
      end
      4'b0100: begin
        case (ext_s)
          4'b0000: dec_load_s  = 1'b1;
          4'b0100: dec_store_s = 1'b1;
          4'b1100: begin
            dec_jump_s   = cond_true(rdst_s, psr_r);
            dec_target_s = rf_rd_src;
          end
          default: dec_illegal_s = 1'b1;
        endcase
      end
      4'b1100: begin
        dec_jump_s   = cond_true(rdst_s, psr_r);
        dec_target_s = ipc_r + imm_sext_s;
      end
      default: begin
        if (i_code_s[4]) begin
          dec_alu_s   = 1'b1;
          dec_cont_s  = i_code_s[3:0];
          dec_rdest_s = rf_rd_dst;
          // ADDI, SUBI and CMPI take a signed immediate
          dec_rsrc_s  = (op_s == 4'b0101 || op_s == 4'b1001 || op_s == 4'b1011) ?
                        imm_sext_s : imm_zext_s;
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
    endcase
  end

  // Flag merge: arithmetic ops own C/F, compares own N/Z/L
  always_comb begin
    psr_next_s = psr_r;
    if (dec_alu_s && (dec_cont_s == ALU_ADD || dec_cont_s == ALU_SUB)) begin
      psr_next_s[1:0] = alu_psr[1:0];
    end else if (dec_alu_s && dec_cont_s == ALU_CMP) begin
      psr_next_s[4:2] = alu_psr[4:2];
    end else begin
      psr_next_s = psr_r;
    end
  end

  // Next-state and per-state strobes/operands
  always_comb begin
    next_state_s = S_FETCH;
    mem_addr     = ZERO;
    mem_wdata    = ZERO;
    mem_we       = 1'b0;
    rf_we        = 1'b0;
    rf_wd        = ZERO;
    alu_rsrc     = ZERO;
    alu_rdest    = ZERO;
    alucont      = 4'b0000;
    illegal_op   = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_addr     = pc_r;
        next_state_s = S_LATCH;
      end
      S_LATCH: next_state_s = S_EXEC;
      S_EXEC: begin
        alucont      = dec_cont_s;
        alu_rsrc     = dec_rsrc_s;
        alu_rdest    = dec_rdest_s;
        rf_we        = dec_alu_s & (dec_cont_s != ALU_CMP);
        rf_wd        = rf_we ? alu_result : ZERO;
        mem_we       = dec_store_s;
        mem_addr     = (dec_load_s | dec_store_s) ? rf_rd_src : ZERO;
        mem_wdata    = dec_store_s ? rf_rd_dst : ZERO;
        illegal_op   = dec_illegal_s;
        next_state_s = dec_load_s ? S_LDWB : S_FETCH;
      end
      S_LDWB: begin
        mem_addr     = ld_addr_r;
        rf_we        = 1'b1;
        rf_wd        = mem_rdata;
        next_state_s = S_FETCH;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Architectural registers: IR/IPC/PC in LATCH, PSR/branch/load address in EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r      <= RESET_PC;
      ipc_r     <= RESET_PC;
      ir_r      <= ZERO;
      psr_r     <= 5'b00000;
      ld_addr_r <= ZERO;
    end else if (state_r == S_LATCH) begin
      ir_r  <= mem_rdata;
      ipc_r <= pc_r;
      pc_r  <= pc_r + ONE;
    end else if (state_r == S_EXEC) begin
      psr_r     <= psr_next_s;
      ld_addr_r <= rf_rd_src;
      if (dec_jump_s) begin
        pc_r <= dec_target_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: memory, register file and ALU environment, directed
// scenarios, then random programs checked against an instruction-level model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_we;
  logic [3:0]  rf_ra_src, rf_ra_dst, rf_wa;
  logic [15:0] rf_rd_src, rf_rd_dst, rf_wd;
  logic        rf_we;
  logic [15:0] alu_rsrc, alu_rdest, alu_result;
  logic [3:0]  alucont;
  logic [4:0]  alu_psr, psr;
  logic [15:0] pc;
  logic        illegal_op;

  logic [15:0] mem   [0:65535];
  logic [15:0] regs  [0:15];
  logic [15:0] rmem  [0:65535];
  logic [15:0] rregs [0:15];
  logic [15:0] rpc;
  logic [4:0]  rpsr;
  logic        init_req = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc, diffs;
  logic ill, seen;

  alu_sequencer #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .rf_ra_src(rf_ra_src), .rf_ra_dst(rf_ra_dst), .rf_rd_src(rf_rd_src), .rf_rd_dst(rf_rd_dst),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .alu_rsrc(alu_rsrc), .alu_rdest(alu_rdest), .alucont(alucont),
    .alu_result(alu_result), .alu_psr(alu_psr),
    .psr(psr), .pc(pc), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {N,Z,L,F,C, result}
  function automatic logic [20:0] alu_model(input logic [3:0] c, input logic [15:0] s,
                                            input logic [15:0] d);
    logic [16:0] w;
    logic [15:0] r;
    logic cy, ov, n, z, l;
    int sh;
    w = 17'd0; r = 16'd0; cy = 1'b0; ov = 1'b0;
    case (c)
      4'd0: begin w = {1'b0, d} + {1'b0, s}; r = w[15:0]; cy = w[16];
                  ov = (d[15] == s[15]) && (r[15] != d[15]); end
      4'd1: begin w = {1'b0, d} - {1'b0, s}; r = w[15:0]; cy = w[16];
                  ov = (d[15] != s[15]) && (r[15] != d[15]); end
      4'd2: r = d & s;
      4'd3: r = d ^ s;
      4'd4: r = d | s;
      4'd5: r = d - s;
      4'd6: r = s;
      4'd7, 4'd8: begin
        sh = $signed(s[4:0]);
        if (sh >= 0) r = d << sh;
        else r = d >> (-sh);
      end
      4'd9: r = d << 8;
      default: r = 16'd0;
    endcase
    if (c == 4'd5) begin
      n = $signed(s) > $signed(d); z = (s == d); l = (s > d);
    end else begin
      n = r[15]; z = (r == 16'd0); l = cy ^ ov;
    end
    return {n, z, l, ov, cy, r};
  endfunction

  assign {alu_psr, alu_result} = alu_model(alucont, alu_rsrc, alu_rdest);
  assign rf_rd_src = regs[rf_ra_src];
  assign rf_rd_dst = regs[rf_ra_dst];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 65536; i++) mem[i] <= rmem[i];
      for (int i = 0; i < 16; i++) regs[i] <= rregs[i];
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (rf_we) regs[rf_wa] <= rf_wd;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_start();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1;
  endtask

  // Position of a code in the arithmetic list equals its ALU select
  function automatic int code_idx(input logic [3:0] c);
    case (c)
      4'h5: return 0;
      4'h9: return 1;
      4'h1: return 2;
      4'h3: return 3;
      4'h2: return 4;
      4'hB: return 5;
      4'hD: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] f);
    logic n, z, l, fl, cy;
    {n, z, l, fl, cy} = f;
    case (c)
      4'd0: return z;        4'd1: return !z;
      4'd2: return cy;       4'd3: return !cy;
      4'd4: return l;        4'd5: return !l;
      4'd6: return n;        4'd7: return !n;
      4'd8: return fl;       4'd9: return !fl;
      4'd10: return !l && !z; 4'd11: return l || z;
      4'd12: return !n && !z; 4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One instruction at ISA level: updates rpc/rpsr/rregs/rmem
  task automatic ref_step(output int ncyc, output logic nill);
    logic [15:0] ir, ipc, imm_s, imm_z, s_op, d_op;
    logic [3:0] op, rd, ext, rs, cont;
    logic [20:0] o;
    logic do_alu;
    int k;
    ir = rmem[rpc]; ipc = rpc; rpc = rpc + 16'd1;
    op = ir[15:12]; rd = ir[11:8]; ext = ir[7:4]; rs = ir[3:0];
    imm_s = {{8{ir[7]}}, ir[7:0]};
    imm_z = {8'h00, ir[7:0]};
    ncyc = 3; nill = 1'b0; do_alu = 1'b0; cont = 4'd0; s_op = 16'd0; d_op = rregs[rd];
    if (op == 4'd0 && code_idx(ext) >= 0) begin
      do_alu = 1'b1; cont = 4'(code_idx(ext)); s_op = rregs[rs];
    end else if (op != 4'd0 && code_idx(op) >= 0) begin
      k = code_idx(op);
      do_alu = 1'b1; cont = 4'(k);
      s_op = (k == 0 || k == 1 || k == 5) ? imm_s : imm_z;
    end else if (op == 4'd8 && ext == 4'd4) begin
      do_alu = 1'b1; cont = 4'd7; s_op = rregs[rs];
    end else if (op == 4'd8 && ext <= 4'd1) begin
      do_alu = 1'b1; cont = 4'd8; s_op = {11'd0, ir[4:0]};
    end else if (op == 4'd15) begin
      do_alu = 1'b1; cont = 4'd9; d_op = imm_z;
    end else if (op == 4'd4 && ext == 4'd0) begin
      rregs[rd] = rmem[rregs[rs]]; ncyc = 4;
    end else if (op == 4'd4 && ext == 4'd4) begin
      rmem[rregs[rs]] = rregs[rd];
    end else if (op == 4'd4 && ext == 4'd12) begin
      if (cond_ok(rd, rpsr)) rpc = rregs[rs];
    end else if (op == 4'd12) begin
      if (cond_ok(rd, rpsr)) rpc = ipc + imm_s;
    end else begin
      nill = 1'b1;
    end
    if (do_alu) begin
      o = alu_model(cont, s_op, d_op);
      if (cont != 4'd5) rregs[rd] = o[15:0];
      if (cont <= 4'd1) rpsr[1:0] = o[17:16];
      if (cont == 4'd5) rpsr[4:2] = o[20:18];
    end
  endtask

  function automatic logic [3:0] pick_code();
    case ($urandom_range(0, 6))
      0: return 4'h5; 1: return 4'h9; 2: return 4'h1; 3: return 4'h3;
      4: return 4'h2; 5: return 4'hB; default: return 4'hD;
    endcase
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0: begin r[15:12] = 4'h0; r[7:4] = pick_code(); end
      1, 2: r[15:12] = pick_code();
      3: begin r[15:12] = 4'h8;
               if ($urandom_range(0, 1) == 0) r[7:4] = 4'h4; else r[7:5] = 3'b000; end
      4: r[15:12] = 4'hF;
      5: begin r[15:12] = 4'h4; r[7:4] = 4'h0; end
      6: begin r[15:12] = 4'h4; r[7:4] = 4'h4; end
      7: begin r[15:12] = 4'h4; r[7:4] = 4'hC; end
      8: r[15:12] = 4'hC;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    // Directed program: ADD, CMPI, BUC, ..., LOAD at 000E, STOR at 000F, BEQ at 0010
    for (int i = 0; i < 65536; i++) rmem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) rregs[i] = 16'h0000;
    rmem[16'h0000] = 16'h0152; rmem[16'h0001] = 16'hB3FF; rmem[16'h0002] = 16'hCE0E;
    rmem[16'h000E] = 16'h4405; rmem[16'h000F] = 16'h4647; rmem[16'h0010] = 16'hC0FE;
    rmem[16'h0100] = 16'hBEEF;
    rregs[1] = 16'h7FFF; rregs[2] = 16'h0001; rregs[3] = 16'hFFFF;
    rregs[5] = 16'h0100; rregs[6] = 16'h1234; rregs[7] = 16'h0200;
    load_and_start();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_psr", psr, 5'b00000);
    chk("rst_strobes", {mem_we, rf_we, illegal_op}, 3'b000);
    chk("rst_outs", {mem_addr, alu_rsrc, alu_rdest, alucont}, 52'd0);
    tick(); tick();
    chk("pre_rst_rf_we", rf_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midexec_rst_pc", pc, 16'h0000);
    chk("midexec_rst_psr", psr, 5'b00000);
    chk("midexec_rst_rf_we", rf_we, 1'b0);
    @(negedge clk); @(negedge clk) reset = 1'b0;
    #1;
    chk("no_partial_write", regs[1], 16'h7FFF);
    chk("first_fetch", mem_addr, 16'h0000);

    tick(); tick();
    chk("add_we", {rf_we, rf_wa, alucont}, {1'b1, 4'd1, 4'd0});
    chk("add_wd", rf_wd, 16'h8000);
    tick();
    chk("add_psr", psr, 5'b00010);
    chk("add_pc", pc, 16'h0001);
    chk("add_reg", regs[1], 16'h8000);

    tick(); tick();
    chk("cmpi_rsrc", alu_rsrc, 16'hFFFF);
    chk("cmpi_we", {rf_we, alucont}, {1'b0, 4'b0101});
    tick();
    chk("cmpi_psr", psr, 5'b01010);

    tick(); tick(); tick();
    chk("buc_target", mem_addr, 16'h0010);
    tick(); tick(); tick();
    chk("beq_target", mem_addr, 16'h000E);
    chk("beq_pc", pc, 16'h000E);

    tick(); tick();
    chk("load_addr", mem_addr, 16'h0100);
    chk("load_exec_we", rf_we, 1'b0);
    tick();
    chk("load_wb", {rf_we, rf_wa, rf_wd}, {1'b1, 4'd4, 16'hBEEF});
    chk("load_wb_addr", mem_addr, 16'h0100);
    tick();
    chk("load_4cyc", mem_addr, 16'h000F);

    tick();
    chk("stor_latch_we", mem_we, 1'b0);
    tick();
    chk("stor_exec", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0200, 16'h1234});
    chk("stor_no_rf", rf_we, 1'b0);
    tick();
    chk("stor_after_we", mem_we, 1'b0);
    chk("stor_mem", mem[16'h0200], 16'h1234);
    chk("stor_next", mem_addr, 16'h0010);

    // Jump to FFFF holding an undefined encoding, then wrap to 0000
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) rmem[i] = 16'h0000;
    rmem[16'h0000] = 16'h4EC8;
    rregs[8] = 16'hFFFF;
    load_and_start();
    tick(); tick(); tick();
    chk("jump_ffff", {pc, mem_addr}, {16'hFFFF, 16'hFFFF});
    tick();
    chk("ill_latch", illegal_op, 1'b0);
    tick();
    chk("ill_exec", {illegal_op, rf_we, mem_we}, 3'b100);
    tick();
    chk("ill_after", illegal_op, 1'b0);
    chk("pc_wrap", {pc, mem_addr}, {16'h0000, 16'h0000});

    // Random programs against the instruction-level model
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) rmem[i] = gen_instr();
    for (int i = 0; i < 16; i++) rregs[i] = 16'($urandom);
    rpc = 16'h0000; rpsr = 5'b00000;
    load_and_start();
    chk("rnd_start", mem_addr, 16'h0000);
    for (int n = 0; n < 400; n++) begin
      ref_step(cyc, ill);
      seen = 1'b0;
      for (int c = 0; c < cyc; c++) begin
        if (illegal_op) seen = 1'b1;
        tick();
      end
      chk("rnd_pc", mem_addr, rpc);
      chk("rnd_psr", psr, rpsr);
      chk("rnd_illegal", seen, ill);
    end
    for (int r = 0; r < 16; r++) chk("rnd_reg", regs[r], rregs[r]);
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== rmem[i]) diffs++;
    chk("rnd_mem_diffs", diffs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
